// File: rtl/fork_join_pkg.sv
// Shared types and default widths for the fork/join dispatcher.
package fork_join_pkg;

  localparam int N_THREADS_DEF = 2;
  localparam int CNT_W_DEF     = 8;
  localparam int TS_W_DEF      = 16;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'b00,
    JOIN_ANY  = 2'b01,
    JOIN_NONE = 2'b10,
    JOIN_RSVD = 2'b11
  } join_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/fork_join_ctrl_thread_timer.sv
// One delay thread: loads a cycle count, pulses start, counts down and pulses done.
module thread_timer
  import fork_join_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] delay,
  output logic             busy,
  output logic             start,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             start_q;
  logic             zero_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load && (delay != '0)) begin
      cnt_d  = delay;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // The thread stays busy through the cycle in which the count reaches zero.
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      start_q <= load;
      zero_q  <= load && (delay == '0);
    end
  end

  assign busy  = busy_q;
  assign start = start_q;
  assign done  = (busy_q && (cnt_q == '0)) || zero_q;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join dispatcher: launches per-thread timers and reports the join event per mode.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_THREADS = N_THREADS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TS_W      = TS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fork_valid,
  output logic                       fork_ready,
  input  logic [N_THREADS-1:0]       fork_mask,
  input  logic [1:0]                 fork_mode,
  input  logic [N_THREADS*CNT_W-1:0] fork_delay,
  output logic [N_THREADS-1:0]       thr_busy,
  output logic [N_THREADS-1:0]       thr_start,
  output logic [N_THREADS-1:0]       thr_done,
  output logic                       join_done,
  output logic [TS_W-1:0]            now
);

  state_e               state_q, state_d;
  join_mode_e           mode_q, mode_d;
  logic [N_THREADS-1:0] pending_q, pending_d;
  logic                 imm_q, imm_d;
  logic                 acc_q;
  logic [TS_W-1:0]      now_q;
  logic                 fork_accept;
  logic [N_THREADS-1:0] load;
  logic [N_THREADS-1:0] hit;
  logic [N_THREADS-1:0] left;

  // acc_q holds ready low in the join cycle of an immediate (no-WAIT) join.
  assign fork_ready  = (state_q == IDLE) && !acc_q && ((fork_mask & thr_busy) == '0);
  assign fork_accept = fork_valid && fork_ready;
  assign load        = fork_accept ? fork_mask : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_THREADS; gi++) begin : g_thr
      thread_timer #(.CNT_W(CNT_W)) u_thr (
        .clk   (clk),
        .rst   (rst),
        .load  (load[gi]),
        .delay (fork_delay[gi*CNT_W +: CNT_W]),
        .busy  (thr_busy[gi]),
        .start (thr_start[gi]),
        .done  (thr_done[gi])
      );
    end
  endgenerate

  // Only threads of the fork being joined sit in pending, so stale done pulses are ignored.
  assign hit  = pending_q & thr_done;
  assign left = pending_q & ~thr_done;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    imm_d     = 1'b0;
    join_done = imm_q;
    case (state_q)
      IDLE: begin
        if (fork_accept) begin
          mode_d = join_mode_e'(fork_mode);
          if ((join_mode_e'(fork_mode) == JOIN_NONE) || (fork_mask == '0)) begin
            imm_d = 1'b1;
          end else begin
            state_d   = WAIT;
            pending_d = fork_mask;
          end
        end
      end
      WAIT: begin
        pending_d = left;
        if (mode_q == JOIN_ANY) begin
          if (hit != '0) begin
            join_done = 1'b1;
            state_d   = IDLE;
            pending_d = '0;
          end
        end else if (left == '0) begin
          join_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= JOIN_ALL;
      pending_q <= '0;
      imm_q     <= 1'b0;
      acc_q     <= 1'b0;
      now_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      imm_q     <= imm_d;
      acc_q     <= fork_accept;
      now_q     <= now_q + {{(TS_W-1){1'b0}}, 1'b1};
    end
  end

  assign now = now_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Randomized bench for fork_join_ctrl against a schedule-based reference model.
module tb_fork_join_ctrl;

  localparam int N  = 2;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          fork_valid;
  logic          fork_ready;
  logic [N-1:0]  fork_mask;
  logic [1:0]    fork_mode;
  logic [N*CW-1:0] fork_delay;
  logic [N-1:0]  thr_busy, thr_start, thr_done;
  logic          join_done;
  logic [15:0]   now;

  logic          w_valid;
  logic          w_ready;
  logic [N-1:0]  w_busy, w_start, w_done;
  logic          w_join;
  logic [3:0]    w_now;

  int errors;
  int checks;

  // Schedule of expected events, in cycles since the last reset release.
  longint start_c[N];
  longint done_c[N];
  int     dly[N];
  longint join_c;
  longint cyc;

  fork_join_ctrl #(.N_THREADS(N), .CNT_W(CW), .TS_W(16)) u_dut (
    .clk(clk), .rst(rst), .fork_valid(fork_valid), .fork_ready(fork_ready),
    .fork_mask(fork_mask), .fork_mode(fork_mode), .fork_delay(fork_delay),
    .thr_busy(thr_busy), .thr_start(thr_start), .thr_done(thr_done),
    .join_done(join_done), .now(now)
  );

  fork_join_ctrl #(.N_THREADS(N), .CNT_W(CW), .TS_W(4)) u_dut_w (
    .clk(clk), .rst(rst), .fork_valid(w_valid), .fork_ready(w_ready),
    .fork_mask(fork_mask), .fork_mode(fork_mode), .fork_delay(fork_delay),
    .thr_busy(w_busy), .thr_start(w_start), .thr_done(w_done),
    .join_done(w_join), .now(w_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      start_c[i] = -1;
      done_c[i]  = -1;
      dly[i]     = 0;
    end
    join_c = -1;
    cyc    = 0;
  endtask

  function automatic logic [N-1:0] exp_busy_f();
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++)
      if (start_c[i] >= 0 && dly[i] > 0 && cyc >= start_c[i] && cyc <= done_c[i]) b[i] = 1'b1;
    return b;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  64'(thr_busy),  64'd0);
    check({tag, "_start"}, 64'(thr_start), 64'd0);
    check({tag, "_done"},  64'(thr_done),  64'd0);
    check({tag, "_join"},  64'(join_done), 64'd0);
    check({tag, "_now"},   64'(now),       64'd0);
  endtask

  task automatic random_inputs();
    int r;
    fork_valid = ($urandom_range(0, 2) != 0);
    fork_mask  = N'($urandom_range(0, 3));
    fork_mode  = 2'($urandom_range(0, 3));
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       fork_delay[i*CW +: CW] = '0;
      else if (r == 19) fork_delay[i*CW +: CW] = CW'($urandom_range(100, 255));
      else             fork_delay[i*CW +: CW] = CW'($urandom_range(1, 15));
    end
  endtask

  task automatic model_accept(input longint c);
    int mn, mx, d;
    mn = 1 << 30;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      if (fork_mask[i]) begin
        d = int'(fork_delay[i*CW +: CW]);
        start_c[i] = c + 1;
        done_c[i]  = c + 1 + d;
        dly[i]     = d;
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
    end
    if (fork_mode == 2'b10 || fork_mask == '0) join_c = c + 1;
    else if (fork_mode == 2'b01)               join_c = c + 1 + mn;
    else                                       join_c = c + 1 + mx;
    $display("fork cyc=%0d mask=%b mode=%0d d0=%0d d1=%0d join_at=%0d",
             c, fork_mask, fork_mode, fork_delay[0 +: CW], fork_delay[CW +: CW], join_c);
  endtask

  initial begin
    logic [N-1:0] eb, es, ed;
    logic         er, acc;
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    fork_valid = 1'b0;
    w_valid    = 1'b0;
    fork_mask  = '0;
    fork_mode  = '0;
    fork_delay = '0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_ready", 64'(fork_ready), 64'd1);
    rst = 1'b0;
    clear_model();

    for (int step = 0; step < 3000; step++) begin
      if (step == 1500) begin
        // Asynchronous reset mid-run, with threads likely still in flight.
        fork_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        check("async_rst_wnow", 64'(w_now), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
      end
      random_inputs();
      @(negedge clk);
      eb = exp_busy_f();
      es = '0;
      ed = '0;
      for (int i = 0; i < N; i++) begin
        if (start_c[i] == cyc) es[i] = 1'b1;
        if (done_c[i]  == cyc) ed[i] = 1'b1;
      end
      er = (cyc > join_c) && ((fork_mask & eb) == '0);
      check("ready", 64'(fork_ready), 64'(er));
      check("busy",  64'(thr_busy),   64'(eb));
      check("start", 64'(thr_start),  64'(es));
      check("done",  64'(thr_done),   64'(ed));
      check("join",  64'(join_done),  64'(join_c == cyc));
      check("now",   64'(now),        64'(cyc % 65536));
      check("now_w4", 64'(w_now),     64'(cyc % 16));
      acc = fork_valid && er;
      @(posedge clk);
      if (acc) model_accept(cyc);
      cyc++;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Hardware fork/join dispatcher that launches up to N_THREADS concurrent delay threads from a single fork command.
- Each thread runs for its own programmed cycle count. The controller reports per-thread start/done events and a join event whose timing depends on the join mode: all, any or none.
- It sits upstream of the thread-event checkers and the completion logger in the Threads benches, which consume its start/done/join pulses and timestamp.

Parameters:
- N_THREADS, 2, number of independent thread timers.
- CNT_W, 8, width of each thread's delay field in cycles.
- TS_W, 16, width of the free-running timestamp.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fork_valid  in  1  fork command present.
- fork_ready  out  1  controller can accept a fork this cycle.
- fork_mask  in  N_THREADS  threads launched by this fork.
- fork_mode  in  2  00 JOIN_ALL, 01 JOIN_ANY, 10 JOIN_NONE, 11 reserved (treated as JOIN_ALL).
- fork_delay  in  N_THREADS*CNT_W  per-thread duration; thread i uses slice [i*CNT_W +: CNT_W].
- thr_busy  out  N_THREADS  thread i running.
- thr_start  out  N_THREADS  one-cycle start pulse.
- thr_done  out  N_THREADS  one-cycle completion pulse.
- join_done  out  1  one-cycle join pulse.
- now  out  TS_W  free-running cycle timestamp.

Behaviour:
- Reset (async assert): state IDLE, thr_busy=0, thr_start=0, thr_done=0, join_done=0, now=0. Any running threads are killed with no done pulse.
- now increments every cycle and wraps from all-ones to 0.
- States: IDLE and WAIT.
- fork_ready = (state==IDLE) && ((fork_mask & thr_busy)==0). This combinational path from fork_mask is intentional. A fork targeting a still-busy thread stalls until that thread is free.
- Accept happens at edge T when fork_valid && fork_ready. Captured: mask, mode, delays.
- thr_start[i] pulses in cycle T+1 for each masked thread; thr_busy[i] rises at T+1.
- Thread with delay D≥1: thr_done[i] pulses in cycle T+1+D, and thr_busy[i] falls in the following cycle.
- Thread with delay D=0: thr_start[i] and thr_done[i] both pulse in T+1, thr_busy[i] stays 0, and no counter is loaded.
- JOIN_ALL: WAIT until every masked thread has completed; join_done pulses in the same cycle as the last thr_done.
- JOIN_ANY: join_done pulses in the cycle of the first thr_done. If several threads finish together, join_done still pulses once. Remaining threads keep running and later emit their thr_done normally.
- JOIN_NONE: join_done pulses in T+1 together with the thr_start pulses, and the controller never enters WAIT.
- fork_ready returns in the cycle after join_done, subject to the busy-overlap rule.
- Empty fork_mask: no thr_start; join_done pulses at T+1 in every mode.
- Done pulses from threads of an earlier JOIN_ANY/JOIN_NONE fork never count toward the current fork's join.
- Per-thread counters are CNT_W wide and load D at accept. Maximum duration is 2^CNT_W−1 cycles.

Decomposition:
- Package fork_join_pkg holds:
  - join_mode_e enum: JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_RSVD.
  - state_e enum: IDLE, WAIT.
  - Default width constants.
- Sub-module thread_timer, one instance per thread via generate.
  - Inputs: load, delay. Outputs: busy, start, done.
  - Implements the down-counter and the D=0 rule.
- Top level owns the FSM, join tracking (a pending-mask register cleared by the current fork's done pulses), the fork_ready logic and the now counter.

Test Plan:
- JOIN_NONE, mask=11, delays {30,20}, accept at now=5 → thr_start=11 and join_done at now=6; thr_done[0] at now=26; thr_done[1] at now=36; fork_ready=1 at now=7.
- JOIN_ALL, mask=11, delays {30,20}, accept at now=5 → join_done only at now=36, coincident with thr_done[1]; fork_ready=0 during now=6..36 and 1 at now=37.
- JOIN_ANY, mask=11, delays {5,5}, accept at now=0 → thr_done=11 and a single join_done at now=6. A new fork with mask=01 is stalled while thread 0 is busy (busy clears at now=7); the same fork with mask=00 is accepted at now=7.
- Mask=01, delay 0, JOIN_ALL, accept at now=3 → thr_start[0], thr_done[0] and join_done all at now=4; thr_busy stays 0.
- Mask=11, JOIN_ALL, delays {40,40}; assert rst at now=20 → all outputs 0 immediately, with no thr_done or join_done afterwards. After release, fork_ready=1 and now counts from 0.
- now wrap with TS_W=4 → sequence ..14, 15, 0, 1.
